// File: rtl/loadnoc_ctrl.sv
// ============================================================================
// loadnoc_ctrl
// Snoops stores into the NoC load register window, sequences word-by-word NoC
// load beats over a req/ack handshake and writes a completion status word back
// through the MMR write port it shares with writeback stores.
// Optional ack watchdog: define LOADNOC_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module loadnoc_ctrl #(
    parameter logic [31:0] MMR_BASE    = 32'h0000_4000,
    parameter int          LEN_W       = 16,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_we,
    input  logic [31:0] wb_location,
    input  logic [31:0] wb_data,
    output logic        mmr_we,
    output logic [31:0] mmr_location,
    output logic [31:0] loadnoc_data_from_wb,
    output logic        noc_req,
    output logic [31:0] noc_src,
    output logic [31:0] noc_dst,
    input  logic        noc_ack,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DONE  = 2'd2,
        S_WSTAT = 2'd3
    } state_t;

    localparam logic [5:0]  IDX_SRC    = 6'd0;
    localparam logic [5:0]  IDX_DST    = 6'd1;
    localparam logic [5:0]  IDX_LEN    = 6'd2;
    localparam logic [5:0]  IDX_CTRL   = 6'd3;
    localparam logic [31:0] STATUS_LOC = MMR_BASE + 32'd16;

    state_t             state_q, state_d;
    logic [31:0]        shadow_src_q, shadow_src_d;
    logic [31:0]        shadow_dst_q, shadow_dst_d;
    logic [LEN_W-1:0]   shadow_len_q, shadow_len_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic               error_q, error_d;
    logic [31:0]        status_q, status_d;
    logic               mmr_we_q, mmr_we_d;
    logic [31:0]        mmr_loc_q, mmr_loc_d;
    logic [31:0]        mmr_data_q, mmr_data_d;
    logic               noc_req_q, noc_req_d;
    logic               busy_q, busy_d;

    logic               win_hit;
    logic [5:0]         win_idx;
    logic               start_wr;
    logic [LEN_W-1:0]   count_inc;
    logic               timeout_hit;

`ifdef LOADNOC_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    logic [TO_W-1:0] timer_q, timer_d;
    assign timeout_hit = (timer_q == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    assign win_hit   = wb_we && (wb_location[31:8] == MMR_BASE[31:8]);
    assign win_idx   = wb_location[7:2];
    assign start_wr  = win_hit && (win_idx == IDX_CTRL) && wb_data[0];
    assign count_inc = count_q + LEN_W'(1);

    always_comb begin
        state_d      = state_q;
        shadow_src_d = shadow_src_q;
        shadow_dst_d = shadow_dst_q;
        shadow_len_d = shadow_len_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        count_d      = count_q;
        error_d      = error_q;
        status_d     = status_q;
        mmr_we_d     = 1'b0;
        mmr_loc_d    = mmr_loc_q;
        mmr_data_d   = mmr_data_q;
`ifdef LOADNOC_TIMEOUT_EN
        timer_d      = timer_q;
`endif

        // Shadows track every window store, even mid-transfer, for the next start.
        if (win_hit) begin
            case (win_idx)
                IDX_SRC: shadow_src_d = wb_data;
                IDX_DST: shadow_dst_d = wb_data;
                IDX_LEN: shadow_len_d = wb_data[LEN_W-1:0];
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (start_wr) begin
                    src_d   = shadow_src_q;
                    dst_d   = shadow_dst_q;
                    len_d   = shadow_len_q;
                    count_d = '0;
                    error_d = 1'b0;
`ifdef LOADNOC_TIMEOUT_EN
                    timer_d = '0;
`endif
                    state_d = (shadow_len_q == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (noc_ack) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    count_d = count_inc;
`ifdef LOADNOC_TIMEOUT_EN
                    timer_d = '0;
`endif
                    if (count_inc == len_q) begin
                        state_d = S_DONE;
                    end
                end else if (timeout_hit) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
`ifdef LOADNOC_TIMEOUT_EN
                    timer_d = timer_q + TO_W'(1);
`endif
                end
            end
            S_DONE: begin
                status_d = {16'(count_q), 14'd0, error_q, 1'b1};
                state_d  = S_WSTAT;
            end
            S_WSTAT: begin
                // Status waits for a free port cycle; writeback always has priority.
                if (!wb_we) begin
                    mmr_we_d   = 1'b1;
                    mmr_loc_d  = STATUS_LOC;
                    mmr_data_d = status_q;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wb_we) begin
            mmr_we_d   = 1'b1;
            mmr_loc_d  = wb_location;
            mmr_data_d = wb_data;
        end

        noc_req_d = (state_d == S_REQ);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            shadow_src_q <= '0;
            shadow_dst_q <= '0;
            shadow_len_q <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            count_q      <= '0;
            error_q      <= 1'b0;
            status_q     <= '0;
            mmr_we_q     <= 1'b0;
            mmr_loc_q    <= '0;
            mmr_data_q   <= '0;
            noc_req_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef LOADNOC_TIMEOUT_EN
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            shadow_src_q <= shadow_src_d;
            shadow_dst_q <= shadow_dst_d;
            shadow_len_q <= shadow_len_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            count_q      <= count_d;
            error_q      <= error_d;
            status_q     <= status_d;
            mmr_we_q     <= mmr_we_d;
            mmr_loc_q    <= mmr_loc_d;
            mmr_data_q   <= mmr_data_d;
            noc_req_q    <= noc_req_d;
            busy_q       <= busy_d;
`ifdef LOADNOC_TIMEOUT_EN
            timer_q      <= timer_d;
`endif
        end
    end

    assign mmr_we               = mmr_we_q;
    assign mmr_location         = mmr_loc_q;
    assign loadnoc_data_from_wb = mmr_data_q;
    assign noc_req              = noc_req_q;
    assign noc_src              = src_q;
    assign noc_dst              = dst_q;
    assign busy                 = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_loadnoc_ctrl.sv
// ============================================================================
// tb_loadnoc_ctrl
// Directed scoreboard bench for loadnoc_ctrl: expected MMR writes and NoC beats
// are queued as stimulus is driven and compared as the DUT produces them.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_loadnoc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_we = 1'b0;
    logic [31:0] wb_location = '0;
    logic [31:0] wb_data = '0;
    logic        noc_ack = 1'b0;
    logic        mmr_we;
    logic [31:0] mmr_location;
    logic [31:0] loadnoc_data_from_wb;
    logic        noc_req;
    logic [31:0] noc_src;
    logic [31:0] noc_dst;
    logic        busy;

    logic [63:0] mmr_q[$];
    logic [63:0] beat_q[$];
    int total = 0;
    int passed = 0;
    int failed = 0;
    int req_cycles = 0;

    loadnoc_ctrl #(
        .MMR_BASE    (32'h0000_4000),
        .LEN_W       (16),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .wb_we                (wb_we),
        .wb_location          (wb_location),
        .wb_data              (wb_data),
        .mmr_we               (mmr_we),
        .mmr_location         (mmr_location),
        .loadnoc_data_from_wb (loadnoc_data_from_wb),
        .noc_req              (noc_req),
        .noc_src              (noc_src),
        .noc_dst              (noc_dst),
        .noc_ack              (noc_ack),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (rst_n) begin
            if (noc_req) req_cycles++;
            if (noc_req && noc_ack) begin
                e = (beat_q.size() != 0) ? beat_q.pop_front() : '1;
                check("beat_src_dst", {noc_src, noc_dst}, e);
            end
            if (mmr_we) begin
                e = (mmr_q.size() != 0) ? mmr_q.pop_front() : '1;
                check("mmr_write", {mmr_location, loadnoc_data_from_wb}, e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [31:0] loc, input logic [31:0] data);
        wb_we       = 1'b1;
        wb_location = loc;
        wb_data     = data;
        mmr_q.push_back({loc, data});
        step();
        wb_we = 1'b0;
    endtask

    task automatic push_beats(input logic [31:0] src, input logic [31:0] dst, input int n);
        for (int i = 0; i < n; i++) begin
            beat_q.push_back({src + 32'(4 * i), dst + 32'(4 * i)});
        end
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (busy === 1'b1 && n < maxc) begin
            step();
            n++;
        end
        check("busy_falls", busy, 1'b0);
        repeat (2) step();
        check("beats_drained", beat_q.size(), 0);
        check("mmr_drained", mmr_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_mmr_we", mmr_we, 1'b0);
        check("rst_mmr_loc", mmr_location, 32'h0);
        check("rst_mmr_data", loadnoc_data_from_wb, 32'h0);
        check("rst_noc_req", noc_req, 1'b0);
        check("rst_noc_src", noc_src, 32'h0);
        check("rst_noc_dst", noc_dst, 32'h0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        step();

        // Basic 3-beat transfer with ack held high
        noc_ack = 1'b1;
        wb_write(32'h4000, 32'h100);
        wb_write(32'h4004, 32'h200);
        wb_write(32'h4008, 32'd3);
        push_beats(32'h100, 32'h200, 3);
        wb_write(32'h400C, 32'h1);
        mmr_q.push_back({32'h4010, 32'h0003_0001});
        check("start_busy", busy, 1'b1);
        check("start_req", noc_req, 1'b1);
        check("start_src", noc_src, 32'h100);
        wait_done(40);

        // LEN=0: straight to status, no request
        req_cycles = 0;
        wb_write(32'h4008, 32'd0);
        wb_write(32'h400C, 32'h1);
        mmr_q.push_back({32'h4010, 32'h0000_0001});
        check("len0_busy", busy, 1'b1);
        wait_done(40);
        check("len0_no_req", req_cycles, 0);

        // Status write deferred by 4 back-to-back writeback stores
        wb_write(32'h4008, 32'd1);
        push_beats(32'h100, 32'h200, 1);
        wb_write(32'h400C, 32'h1);
        wb_write(32'h4010, 32'hDEAD_0000);
        wb_write(32'h5000, 32'h0000_0001);
        wb_write(32'h4010, 32'hDEAD_0002);
        wb_write(32'h0000_0000, 32'h0000_0003);
        mmr_q.push_back({32'h4010, 32'h0001_0001});
        check("defer_busy", busy, 1'b1);
        step();
        check("defer_stat_we", mmr_we, 1'b1);
        check("defer_stat_loc", mmr_location, 32'h4010);
        check("defer_stat_data", loadnoc_data_from_wb, 32'h0001_0001);
        wait_done(40);

        // Start while busy ignored; LEN rewrite only affects the next start
        noc_ack = 1'b0;
        wb_write(32'h4000, 32'h1000);
        wb_write(32'h4004, 32'h2000);
        wb_write(32'h4008, 32'd2);
        push_beats(32'h1000, 32'h2000, 2);
        wb_write(32'h400C, 32'h1);
        wb_write(32'h4008, 32'd5);
        wb_write(32'h400C, 32'h1);
        step();
        step();
        check("stall_req", noc_req, 1'b1);
        check("stall_src", noc_src, 32'h1000);
        check("stall_dst", noc_dst, 32'h2000);
        mmr_q.push_back({32'h4010, 32'h0002_0001});
        noc_ack = 1'b1;
        wait_done(40);
        push_beats(32'h1000, 32'h2000, 5);
        wb_write(32'h400C, 32'h1);
        mmr_q.push_back({32'h4010, 32'h0005_0001});
        wait_done(40);

`ifdef LOADNOC_TIMEOUT_EN
        // Two beats then a stalled ack trips the watchdog
        wb_write(32'h4008, 32'd5);
        push_beats(32'h1000, 32'h2000, 2);
        wb_write(32'h400C, 32'h1);
        step();
        step();
        noc_ack = 1'b0;
        mmr_q.push_back({32'h4010, 32'h0002_0003});
        wait_done(40);
`endif

        // Asynchronous reset in the middle of REQ
        noc_ack = 1'b0;
        wb_write(32'h4008, 32'd4);
        wb_write(32'h400C, 32'h1);
        step();
        step();
        check("prerst_req", noc_req, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_noc_req", noc_req, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_mmr_we", mmr_we, 1'b0);
        check("arst_mmr_loc", mmr_location, 32'h0);
        check("arst_mmr_data", loadnoc_data_from_wb, 32'h0);
        check("arst_noc_src", noc_src, 32'h0);
        check("arst_noc_dst", noc_dst, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        wb_write(32'h4000, 32'h40);
        wb_write(32'h4004, 32'h80);
        wb_write(32'h4008, 32'd2);
        noc_ack = 1'b1;
        push_beats(32'h40, 32'h80, 2);
        wb_write(32'h400C, 32'h1);
        mmr_q.push_back({32'h4010, 32'h0002_0001});
        check("post_rst_busy", busy, 1'b1);
        wait_done(40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
